seven_seg_display_arbiter: RTL and testbench

//   Shares the single 16-bit four-digit display word between NUM_REQ requesters
//   (e.g. UART rx byte, morse decoder symbol, status/error code). Each granted

---
 rtl/seven_seg_display_arbiter.sv | 148 ++++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter
// Round-robin arbiter that shares one 16-bit display word between NUM_REQ
// requesters. Each granted word is latched and held for HOLD_CYCLES clocks;
// IDLE_DATA is shown whenever nobody holds the display.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | nothing held, display shows IDLE_DATA, waiting for a request
//   S_HOLD | a granted word is on the display, hold counter running
module seven_seg_display_arbiter #(
    parameter int          NUM_REQ   = 3,
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          HOLD_MS   = 500,
    parameter logic [15:0] IDLE_DATA = 16'h0000,
    localparam int         OWN_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [16*NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [15:0]            disp_data_o,
    output logic [OWN_W-1:0]       owner_o,
    output logic                   busy_o
);

    localparam int HOLD_RAW    = (CLK_FREQ / 1000) * HOLD_MS;
    localparam int HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam int CNT_W       = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWN_W-1:0] PTR_INIT = OWN_W'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OWN_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [15:0]          disp_q, disp_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic                 busy_q, busy_d;

    logic [15:0]          req_word [NUM_REQ];
    logic                 grant_found;
    logic [OWN_W-1:0]     grant_idx;

    // Split the packed message bus into one word per requester
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
        assign req_word[k] = req_data_i[16*k +: 16];
    end

    // Circular search for the first pending request after the last grant
    always_comb begin
        int               idx;
        logic [OWN_W-1:0] idx_sel;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_sel     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx     = (int'(ptr_q) + i) % NUM_REQ;
            idx_sel = OWN_W'(idx);
            if (!grant_found && req_i[idx_sel]) begin
                grant_found = 1'b1;
                grant_idx   = idx_sel;
            end
        end
    end

    // Next-state logic: grant from idle or at hold expiry, otherwise count
    always_comb begin
        logic load;
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        disp_d  = disp_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    load = 1'b1;
                end else begin
                    disp_d = IDLE_DATA;
                    busy_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    // Pending requests take over on the expiry edge, no idle gap
                    if (grant_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        disp_d  = IDLE_DATA;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            ptr_d   = grant_idx;
            ack_d   = NUM_REQ'(1) << grant_idx;
            disp_d  = req_word[grant_idx];
            owner_d = grant_idx;
            busy_d  = 1'b1;
        end
    end

    // State and registered outputs, asynchronously reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_INIT;
            ack_q   <= '0;
            disp_q  <= IDLE_DATA;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign disp_data_o = disp_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed testbench for seven_seg_display_arbiter: 3 requesters, 4-cycle hold,
// idle word 16'hFFFF.
module tb_seven_seg_display_arbiter;

    localparam int NUM_REQ = 3;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [2:0]  req_i;
    logic [47:0] req_data_i;
    logic [2:0]  ack_o;
    logic [15:0] disp_data_o;
    logic [1:0]  owner_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_display_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .CLK_FREQ  (4000),
        .HOLD_MS   (1),
        .IDLE_DATA (16'hFFFF)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .req_data_i  (req_data_i),
        .ack_o       (ack_o),
        .disp_data_o (disp_data_o),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i    = 1'b1;
        req_i      = 3'b000;
        req_data_i = '0;
        tick();
        tick();
        n_checks++;
        if (disp_data_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_disp: got %h expected ffff", disp_data_o);
        end
        n_checks++;
        if (ack_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ack: got %b expected 000", ack_o);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        n_checks++;
        if (owner_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_owner: got %0d expected 0", owner_o);
        end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_i      = 3'b010;
        req_data_i = {16'h0000, 16'h1234, 16'h0000};
        tick();
        n_checks++;
        if (ack_o !== 3'b010 || owner_o !== 2'd1 || busy_o !== 1'b1 || disp_data_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_grant: got ack=%b owner=%0d busy=%b disp=%h expected ack=010 owner=1 busy=1 disp=1234",
                     ack_o, owner_o, busy_o, disp_data_o);
        end
        req_i = 3'b000;
        for (int c = 1; c < 4; c++) begin
            tick();
            n_checks++;
            if (ack_o !== 3'b000 || disp_data_o !== 16'h1234 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL single_hold%0d: got ack=%b disp=%h busy=%b expected ack=000 disp=1234 busy=1",
                         c, ack_o, disp_data_o, busy_o);
            end
        end
        tick();
        n_checks++;
        if (disp_data_o !== 16'hFFFF || busy_o !== 1'b0 || ack_o !== 3'b000) begin
            n_fail++;
            $display("FAIL single_release: got disp=%h busy=%b ack=%b expected disp=ffff busy=0 ack=000",
                     disp_data_o, busy_o, ack_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_own [4];
        logic [15:0] exp_dat [4];
        logic [2:0]  exp_ack;
        exp_own = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_dat = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0A0A};
        reset_i = 1'b1;
        tick();
        reset_i    = 1'b0;
        req_i      = 3'b111;
        req_data_i = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        for (int g = 0; g < 4; g++) begin
            exp_ack = 3'b001 << exp_own[g];
            tick();
            n_checks++;
            if (ack_o !== exp_ack || owner_o !== exp_own[g] || disp_data_o !== exp_dat[g] || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ack=%b owner=%0d disp=%h busy=%b expected ack=%b owner=%0d disp=%h busy=1",
                         g, ack_o, owner_o, disp_data_o, busy_o, exp_ack, exp_own[g], exp_dat[g]);
            end
            for (int c = 1; c < 4; c++) begin
                tick();
                n_checks++;
                if (ack_o !== 3'b000 || disp_data_o !== exp_dat[g]) begin
                    n_fail++;
                    $display("FAIL rr_hold%0d_%0d: got ack=%b disp=%h expected ack=000 disp=%h",
                             g, c, ack_o, disp_data_o, exp_dat[g]);
                end
            end
        end
        req_i = 3'b000;
        tick();
        n_checks++;
        if (disp_data_o !== 16'hFFFF || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_release: got disp=%h busy=%b expected ffff 0", disp_data_o, busy_o);
        end
    endtask

    task automatic test_late_request();
        req_i      = 3'b100;
        req_data_i = {16'h0C0C, 16'h0000, 16'h0000};
        tick();
        n_checks++;
        if (ack_o !== 3'b100 || owner_o !== 2'd2 || disp_data_o !== 16'h0C0C) begin
            n_fail++;
            $display("FAIL late_grant2: got ack=%b owner=%0d disp=%h expected ack=100 owner=2 disp=0c0c",
                     ack_o, owner_o, disp_data_o);
        end
        req_i = 3'b000;
        tick();
        req_i      = 3'b001;
        req_data_i = {16'h0C0C, 16'h0000, 16'h0A0A};
        for (int c = 2; c < 4; c++) begin
            tick();
            n_checks++;
            if (ack_o !== 3'b000 || disp_data_o !== 16'h0C0C || owner_o !== 2'd2) begin
                n_fail++;
                $display("FAIL late_pending%0d: got ack=%b disp=%h owner=%0d expected ack=000 disp=0c0c owner=2",
                         c, ack_o, disp_data_o, owner_o);
            end
        end
        tick();
        n_checks++;
        if (ack_o !== 3'b001 || owner_o !== 2'd0 || disp_data_o !== 16'h0A0A || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL late_grant0: got ack=%b owner=%0d disp=%h busy=%b expected ack=001 owner=0 disp=0a0a busy=1",
                     ack_o, owner_o, disp_data_o, busy_o);
        end
    endtask

    task automatic test_data_stable();
        req_i      = 3'b000;
        req_data_i = {16'h0C0C, 16'h0000, 16'hDEAD};
        for (int c = 1; c < 4; c++) begin
            tick();
            n_checks++;
            if (disp_data_o !== 16'h0A0A) begin
                n_fail++;
                $display("FAIL stable_hold%0d: got disp=%h expected 0a0a", c, disp_data_o);
            end
        end
        tick();
        n_checks++;
        if (disp_data_o !== 16'hFFFF || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stable_release: got disp=%h busy=%b expected ffff 0", disp_data_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_hold();
        req_i      = 3'b010;
        req_data_i = {16'h2222, 16'h1111, 16'h0000};
        tick();
        n_checks++;
        if (ack_o !== 3'b010 || owner_o !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_pregrant: got ack=%b owner=%0d expected ack=010 owner=1", ack_o, owner_o);
        end
        req_i = 3'b000;
        tick();
        tick();
        req_i   = 3'b110;
        reset_i = 1'b1;
        #2;
        n_checks++;
        if (disp_data_o !== 16'hFFFF || ack_o !== 3'b000 || busy_o !== 1'b0 || owner_o !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got disp=%h ack=%b busy=%b owner=%0d expected ffff 000 0 0",
                     disp_data_o, ack_o, busy_o, owner_o);
        end
        tick();
        reset_i = 1'b0;
        tick();
        n_checks++;
        if (ack_o !== 3'b010 || owner_o !== 2'd1 || disp_data_o !== 16'h1111 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_regrant: got ack=%b owner=%0d disp=%h busy=%b expected ack=010 owner=1 disp=1111 busy=1",
                     ack_o, owner_o, disp_data_o, busy_o);
        end
        req_i = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_late_request();
        test_data_stable();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
